// File: rtl/turn_controller.sv
// Turn sequencer for the two-player 9-card bidding game: turn order,
// card legality, handout strobes, per-round scoring and the final verdict.
module turn_controller #(
    parameter int NUM_ROUNDS = 9,
    parameter int CARD_W     = 9,
    parameter int SCORE_W    = 4
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [CARD_W-1:0]  p1_select,
    input  logic               p1_confirm,
    input  logic [CARD_W-1:0]  p2_select,
    input  logic               p2_confirm,
    input  logic [CARD_W-1:0]  p1_card,
    input  logic [CARD_W-1:0]  p2_card,
    input  logic [3:0]         p1_handcard,
    input  logic [3:0]         p2_handcard,
    output logic [CARD_W-1:0]  p1_cardselect,
    output logic [CARD_W-1:0]  p2_cardselect,
    output logic               handout_p1_pulse,
    output logic               handout_p2_pulse,
    output logic               p1_turn,
    output logic               p2_turn,
    output logic               invalid,
    output logic [3:0]         round,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic [1:0]         round_winner,
    output logic               game_over,
    output logic [1:0]         winner
);

    typedef enum logic [2:0] {
        S_WAIT_FIRST,
        S_ISSUE_FIRST,
        S_WAIT_SECOND,
        S_ISSUE_SECOND,
        S_COMPARE,
        S_GAME_OVER
    } state_e;

    state_e             state_q, state_d;
    logic               leader_q, leader_d;
    logic [3:0]         round_q, round_d;
    logic [SCORE_W-1:0] s1_q, s1_d;
    logic [SCORE_W-1:0] s2_q, s2_d;
    logic [1:0]         rw_q, rw_d;
    logic [CARD_W-1:0]  cs1_q, cs1_d;
    logic [CARD_W-1:0]  cs2_q, cs2_d;
    logic               pls1_q, pls1_d;
    logic               pls2_q, pls2_d;
    logic               inv_q, inv_d;

    logic              second;
    logic              waiting;
    logic              mover_p2;
    logic              mv_confirm;
    logic [CARD_W-1:0] mv_sel;
    logic [CARD_W-1:0] mv_used;
    logic              onehot;
    logic              legal;

    // leader_q: 0 = p1 leads, 1 = p2 leads; the second mover is the other one
    assign second   = (state_q == S_WAIT_SECOND) || (state_q == S_ISSUE_SECOND);
    assign waiting  = (state_q == S_WAIT_FIRST) || (state_q == S_WAIT_SECOND);
    assign mover_p2 = leader_q ^ second;

    assign mv_confirm = mover_p2 ? p2_confirm : p1_confirm;
    assign mv_sel     = mover_p2 ? p2_select  : p1_select;
    assign mv_used    = mover_p2 ? p2_card    : p1_card;

    assign onehot = (mv_sel != '0) &&
                    ((mv_sel & (mv_sel - CARD_W'(1))) == '0);
    assign legal  = waiting && mv_confirm && onehot &&
                    ((mv_sel & mv_used) == '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_WAIT_FIRST;
            leader_q <= 1'b0;
            round_q  <= 4'd1;
            s1_q     <= '0;
            s2_q     <= '0;
            rw_q     <= 2'b00;
            cs1_q    <= '0;
            cs2_q    <= '0;
            pls1_q   <= 1'b0;
            pls2_q   <= 1'b0;
            inv_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            leader_q <= leader_d;
            round_q  <= round_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            rw_q     <= rw_d;
            cs1_q    <= cs1_d;
            cs2_q    <= cs2_d;
            pls1_q   <= pls1_d;
            pls2_q   <= pls2_d;
            inv_q    <= inv_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        leader_d = leader_q;
        round_d  = round_q;
        s1_d     = s1_q;
        s2_d     = s2_q;
        rw_d     = rw_q;
        cs1_d    = cs1_q;
        cs2_d    = cs2_q;
        pls1_d   = 1'b0;
        pls2_d   = 1'b0;
        inv_d    = 1'b0;
        unique case (state_q)
            S_WAIT_FIRST, S_WAIT_SECOND: begin
                if (legal) begin
                    state_d = second ? S_ISSUE_SECOND : S_ISSUE_FIRST;
                    if (mover_p2) begin
                        cs2_d  = mv_sel;
                        pls2_d = 1'b1;
                    end else begin
                        cs1_d  = mv_sel;
                        pls1_d = 1'b1;
                    end
                end else if (mv_confirm) begin
                    inv_d = 1'b1;
                end
            end
            S_ISSUE_FIRST:  state_d = S_WAIT_SECOND;
            S_ISSUE_SECOND: state_d = S_COMPARE;
            S_COMPARE: begin
                unique case (1'b1)
                    (p1_handcard > p2_handcard): begin
                        s1_d     = s1_q + SCORE_W'(1);
                        rw_d     = 2'b01;
                        leader_d = 1'b0;
                    end
                    (p2_handcard > p1_handcard): begin
                        s2_d     = s2_q + SCORE_W'(1);
                        rw_d     = 2'b10;
                        leader_d = 1'b1;
                    end
                    default: rw_d = 2'b11;
                endcase
                if (round_q == 4'(NUM_ROUNDS)) begin
                    state_d = S_GAME_OVER;
                end else begin
                    round_d = round_q + 4'd1;
                    state_d = S_WAIT_FIRST;
                end
            end
            S_GAME_OVER: state_d = S_GAME_OVER;
            default:     state_d = S_WAIT_FIRST;
        endcase
    end

    always_comb begin
        p1_turn   = waiting && !mover_p2;
        p2_turn   = waiting && mover_p2;
        game_over = (state_q == S_GAME_OVER);
        winner    = 2'b00;
        if (game_over) begin
            unique case (1'b1)
                (s1_q > s2_q): winner = 2'b01;
                (s2_q > s1_q): winner = 2'b10;
                default:       winner = 2'b11;
            endcase
        end
    end

    assign p1_cardselect    = cs1_q;
    assign p2_cardselect    = cs2_q;
    assign handout_p1_pulse = pls1_q;
    assign handout_p2_pulse = pls2_q;
    assign invalid          = inv_q;
    assign round            = round_q;
    assign p1_score         = s1_q;
    assign p2_score         = s2_q;
    assign round_winner     = rw_q;

endmodule

// File: tb/tb_turn_controller.sv
// Bench for turn_controller: directed scenarios plus random play,
// checked against a game-level model with handout instances modelled here.
module tb_turn_controller;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [8:0] p1_select = '0;
    logic       p1_confirm = 1'b0;
    logic [8:0] p2_select = '0;
    logic       p2_confirm = 1'b0;
    logic [8:0] p1_card;
    logic [8:0] p2_card;
    logic [3:0] p1_handcard;
    logic [3:0] p2_handcard;
    logic [8:0] p1_cardselect;
    logic [8:0] p2_cardselect;
    logic       handout_p1_pulse;
    logic       handout_p2_pulse;
    logic       p1_turn;
    logic       p2_turn;
    logic       invalid;
    logic [3:0] round;
    logic [3:0] p1_score;
    logic [3:0] p2_score;
    logic [1:0] round_winner;
    logic       game_over;
    logic [1:0] winner;

    int total = 0;
    int bad = 0;

    // game-level reference model
    int         m_leader;
    bit         m_second;
    int         m_round;
    int         m_s1, m_s2, m_rw;
    bit         m_over;
    int         m_v1, m_v2;
    logic [8:0] m_used1, m_used2, m_cs1, m_cs2;

    turn_controller dut (
        .clk              (clk),
        .resetn           (resetn),
        .p1_select        (p1_select),
        .p1_confirm       (p1_confirm),
        .p2_select        (p2_select),
        .p2_confirm       (p2_confirm),
        .p1_card          (p1_card),
        .p2_card          (p2_card),
        .p1_handcard      (p1_handcard),
        .p2_handcard      (p2_handcard),
        .p1_cardselect    (p1_cardselect),
        .p2_cardselect    (p2_cardselect),
        .handout_p1_pulse (handout_p1_pulse),
        .handout_p2_pulse (handout_p2_pulse),
        .p1_turn          (p1_turn),
        .p2_turn          (p2_turn),
        .invalid          (invalid),
        .round            (round),
        .p1_score         (p1_score),
        .p2_score         (p2_score),
        .round_winner     (round_winner),
        .game_over        (game_over),
        .winner           (winner)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] idx(logic [8:0] s);
        logic [3:0] r = 4'd0;
        for (int i = 0; i < 9; i++)
            if (s[i]) r = 4'(i);
        return r;
    endfunction

    // handout instances: latch the card on the strobe edge
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            p1_card     <= '0;
            p2_card     <= '0;
            p1_handcard <= '0;
            p2_handcard <= '0;
        end else begin
            if (handout_p1_pulse) begin
                p1_card     <= p1_card | p1_cardselect;
                p1_handcard <= idx(p1_cardselect);
            end
            if (handout_p2_pulse) begin
                p2_card     <= p2_card | p2_cardselect;
                p2_handcard <= idx(p2_cardselect);
            end
        end
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_leader = 1;
        m_second = 0;
        m_round  = 1;
        m_s1 = 0;
        m_s2 = 0;
        m_rw = 0;
        m_over = 0;
        m_used1 = '0;
        m_used2 = '0;
        m_cs1 = '0;
        m_cs2 = '0;
    endtask

    task automatic check_state(string tag);
        int mv = m_second ? 3 - m_leader : m_leader;
        int w = 0;
        if (m_over) w = (m_s1 > m_s2) ? 1 : (m_s2 > m_s1) ? 2 : 3;
        chk({tag, "_p1turn"}, p1_turn, !m_over && mv == 1);
        chk({tag, "_p2turn"}, p2_turn, !m_over && mv == 2);
        chk({tag, "_round"}, round, m_round);
        chk({tag, "_s1"}, p1_score, m_s1);
        chk({tag, "_s2"}, p2_score, m_s2);
        chk({tag, "_rw"}, round_winner, m_rw);
        chk({tag, "_over"}, game_over, m_over);
        chk({tag, "_winner"}, winner, w);
        chk({tag, "_cs1"}, p1_cardselect, m_cs1);
        chk({tag, "_cs2"}, p2_cardselect, m_cs2);
    endtask

    task automatic check_reset_vals(string tag);
        chk({tag, "_p1turn"}, p1_turn, 1);
        chk({tag, "_p2turn"}, p2_turn, 0);
        chk({tag, "_round"}, round, 1);
        chk({tag, "_scores"}, {p1_score, p2_score}, 0);
        chk({tag, "_rw"}, round_winner, 0);
        chk({tag, "_pulses"}, {handout_p1_pulse, handout_p2_pulse}, 0);
        chk({tag, "_cs"}, {p1_cardselect, p2_cardselect}, 0);
        chk({tag, "_inv"}, invalid, 0);
        chk({tag, "_over"}, {game_over, winner}, 0);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        p1_confirm = 1'b0;
        p2_confirm = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_vals("rst");
        resetn = 1'b1;
        model_reset();
        @(negedge clk);
        check_state("post_rst");
    endtask

    task automatic step(bit c1, bit c2, logic [8:0] s1, logic [8:0] s2);
        int         mv;
        bit         act, legal;
        logic [8:0] sel, used;
        p1_select  = s1;
        p2_select  = s2;
        p1_confirm = c1;
        p2_confirm = c2;
        @(negedge clk);
        p1_confirm = 1'b0;
        p2_confirm = 1'b0;
        if (m_over) begin
            chk("over_pulses", {handout_p1_pulse, handout_p2_pulse}, 0);
            chk("over_inv", invalid, 0);
            check_state("over");
            return;
        end
        mv    = m_second ? 3 - m_leader : m_leader;
        act   = (mv == 1) ? c1 : c2;
        sel   = (mv == 1) ? s1 : s2;
        used  = (mv == 1) ? m_used1 : m_used2;
        legal = act && ($countones(sel) == 1) && ((sel & used) == 0);
        chk("invalid", invalid, act && !legal);
        chk("pulse1", handout_p1_pulse, legal && mv == 1);
        chk("pulse2", handout_p2_pulse, legal && mv == 2);
        if (!legal) begin
            @(negedge clk);
            chk("invalid_1cyc", invalid, 0);
            check_state("hold");
            return;
        end
        if (mv == 1) begin
            m_cs1 = sel;
            m_used1 |= sel;
            m_v1 = idx(sel);
        end else begin
            m_cs2 = sel;
            m_used2 |= sel;
            m_v2 = idx(sel);
        end
        chk("issue_cs1", p1_cardselect, m_cs1);
        chk("issue_cs2", p2_cardselect, m_cs2);
        chk("issue_turns", {p1_turn, p2_turn}, 0);
        @(negedge clk);
        chk("pulse_1cyc", {handout_p1_pulse, handout_p2_pulse}, 0);
        if (!m_second) begin
            m_second = 1;
        end else begin
            @(negedge clk);
            @(negedge clk);
            m_second = 0;
            if (m_v1 > m_v2) begin
                m_s1++;
                m_rw = 1;
                m_leader = 1;
            end else if (m_v2 > m_v1) begin
                m_s2++;
                m_rw = 2;
                m_leader = 2;
            end else begin
                m_rw = 3;
            end
            if (m_round == 9) m_over = 1;
            else m_round++;
        end
        check_state("after");
    endtask

    task automatic play_round(int v1, int v2);
        logic [8:0] a = 9'(1) << v1;
        logic [8:0] b = 9'(1) << v2;
        if (m_leader == 1) begin
            step(1, 0, a, 0);
            step(0, 1, 0, b);
        end else begin
            step(0, 1, 0, b);
            step(1, 0, a, 0);
        end
    endtask

    function automatic logic [8:0] rnd_sel(logic [8:0] used);
        int k = $urandom_range(0, 9);
        int i;
        if (k < 6 && used != 9'h1ff) begin
            do i = $urandom_range(0, 8); while (used[i]);
            return 9'(1) << i;
        end
        if (k < 8) return 9'(1) << $urandom_range(0, 8);
        return 9'($urandom);
    endfunction

    initial begin
        model_reset();
        do_reset();

        // basic round: 4 vs 2
        play_round(4, 2);
        chk("basic_s1", p1_score, 1);
        chk("basic_rw", round_winner, 1);
        chk("basic_round", round, 2);
        chk("basic_p1turn", p1_turn, 1);

        // rejections in p1's turn
        step(1, 0, 9'b000000011, 0);
        step(1, 0, 9'b000000000, 0);
        step(1, 0, 9'b000010000, 0);
        step(0, 1, 0, 9'b000000001);
        chk("rej_round", round, 2);

        // tie then p2 win
        play_round(5, 5);
        chk("tie_rw", round_winner, 3);
        chk("tie_scores", {p1_score, p2_score}, {4'd1, 4'd0});
        chk("tie_lead", p1_turn, 1);
        play_round(0, 6);
        chk("p2win_rw", round_winner, 2);
        chk("p2win_lead", {p1_turn, p2_turn}, 2'b01);

        // full game
        do_reset();
        for (int r = 1; r <= 9; r++) play_round(9 - r, r - 1);
        chk("full_over", game_over, 1);
        chk("full_scores", {p1_score, p2_score}, {4'd4, 4'd4});
        chk("full_winner", winner, 3);
        chk("full_round", round, 9);
        step(1, 1, 9'b000000001, 9'b000000001);
        step(1, 0, 9'b000000011, 0);

        // random games
        for (int g = 0; g < 3; g++) begin
            do_reset();
            for (int i = 0; i < 250 && !m_over; i++)
                step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     rnd_sel(m_used1), rnd_sel(m_used2));
            step(1, 1, rnd_sel(m_used1), rnd_sel(m_used2));
        end

        // async reset during ISSUE_SECOND
        do_reset();
        step(1, 0, 9'b000001000, 0);
        p2_select  = 9'b000000010;
        p2_confirm = 1'b1;
        @(posedge clk);
        #1 p2_confirm = 1'b0;
        #2;
        chk("pre_rst_pulse2", handout_p2_pulse, 1);
        resetn = 1'b0;
        #1;
        chk("async_pulse2", handout_p2_pulse, 0);
        check_reset_vals("async");
        chk("async_mask", p2_card, 0);
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
        @(negedge clk);
        check_state("async_rel");
        play_round(7, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
